// File: rtl/rc_result_fifo_if.sv
// rc_result_fifo_if: push/pop handshake bundle for rc_result_fifo.
// master : FSM producer plus result reader (drives offers, accepts head).
// slave  : the FIFO itself.
interface rc_result_fifo_if #(
  parameter int DATA_W = 4,
  parameter int ST_W   = 2
);
  logic [DATA_W-1:0]      rc_in;
  logic [ST_W-1:0]        state_in;
  logic                   in_valid;
  logic                   in_ready;
  logic [ST_W+DATA_W-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output rc_in, state_in, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  rc_in, state_in, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/rc_result_fifo.sv
// rc_result_fifo: captures {present_state, RC} pairs from the datapath FSM
// into a small first-word-fall-through FIFO for a slower result reader.
// Fill state is tracked by a three-process EMPTY/PARTIAL/FULL FSM, and a
// sticky overflow bit records any offer refused while FULL.
// Optional build macro: RC_FIFO_CHECKSUM_EN adds a running checksum output
// (sum of popped rc fields modulo 2^DATA_W).
module rc_result_fifo #(
  parameter int DATA_W = 4,
  parameter int ST_W   = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  rc_result_fifo_if.slave     bus,
  output logic [CNT_W-1:0]    count,
  output logic [1:0]          fill_state,
  output logic                overflow
`ifdef RC_FIFO_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = ST_W + DATA_W;

  localparam logic [1:0] ST_EMPTY   = 2'b00;
  localparam logic [1:0] ST_PARTIAL = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             r_overflow;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;

  // Handshake qualifiers; a flush suppresses both transfers in its cycle.
  always_comb begin
    w_push = bus.in_valid & w_in_ready  & ~clear;
    w_pop  = w_out_valid  & bus.out_ready & ~clear;
  end

  // Occupancy after this edge, used both for the count register and the FSM.
  always_comb begin
    w_count_next = r_count;
    if (clear) begin
      w_count_next = {CNT_W{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CNT_W'(1);
        2'b01:   w_count_next = r_count - CNT_W'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  // Fill FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fill FSM next-state logic, driven by the next occupancy.
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_next = ST_PARTIAL;
          end else begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_PARTIAL: begin
          if (w_count_next == CNT_W'(DEPTH)) begin
            w_state_next = ST_FULL;
          end else if (w_count_next == {CNT_W{1'b0}}) begin
            w_state_next = ST_EMPTY;
          end else begin
            w_state_next = ST_PARTIAL;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_next = ST_PARTIAL;
          end else begin
            w_state_next = ST_FULL;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Fill FSM outputs: handshake readiness decoded from the registered state.
  always_comb begin
    w_in_ready  = (r_state != ST_FULL);
    w_out_valid = (r_state != ST_EMPTY);
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      if (bus.in_valid && (r_state == ST_FULL)) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
    end
  end

  // Storage write; contents need no reset since out_valid gates the head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.state_in, bus.rc_in};
    end
  end

`ifdef RC_FIFO_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Running sum of the rc field of every popped entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum <= {DATA_W{1'b0}};
    end else if (clear) begin
      r_checksum <= {DATA_W{1'b0}};
    end else if (w_pop) begin
      r_checksum <= r_checksum + r_mem[r_rd_ptr][DATA_W-1:0];
    end else begin
      r_checksum <= r_checksum;
    end
  end

  assign checksum = r_checksum;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_mem[r_rd_ptr];
  assign count         = r_count;
  assign fill_state    = r_state;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_rc_result_fifo.sv
// tb_rc_result_fifo: table-driven vectors plus hand-written sequences for
// rc_result_fifo, with a queue scoreboard holding the expected FIFO contents.
module tb_rc_result_fifo;

  localparam int DATA_W = 4;
  localparam int ST_W   = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic             clk;
  logic             reset;
  logic             clear;
  logic [CNT_W-1:0] count;
  logic [1:0]       fill_state;
  logic             overflow;
`ifdef RC_FIFO_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  rc_result_fifo_if #(.DATA_W(DATA_W), .ST_W(ST_W)) bus ();

  rc_result_fifo #(
    .DATA_W(DATA_W), .ST_W(ST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .bus        (bus),
    .count      (count),
    .fill_state (fill_state),
    .overflow   (overflow)
`ifdef RC_FIFO_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Scoreboard: expected FIFO contents, plus model overflow and checksum.
  logic [ST_W+DATA_W-1:0] q[$];
  logic                   m_ovf;
  logic [DATA_W-1:0]      m_csum;

  typedef struct {
    logic             iv;
    logic [ST_W-1:0]  st;
    logic [DATA_W-1:0] rc;
    logic             ordy;
    logic             clr;
    int               e_cnt;
    logic [1:0]       e_fill;
    logic             e_ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [1:0] model_fill();
    if (q.size() == 0) return 2'b00;
    else if (q.size() == DEPTH) return 2'b10;
    else return 2'b01;
  endfunction

  // One clock: called just after a negedge, returns just after the next negedge.
  task automatic step(input logic iv, input logic [ST_W-1:0] st, input logic [DATA_W-1:0] rc,
                      input logic ordy, input logic clr);
    int pre;
    logic [ST_W+DATA_W-1:0] exp;
    bus.in_valid  = iv;
    bus.state_in  = st;
    bus.rc_in     = rc;
    bus.out_ready = ordy;
    clear         = clr;
    #1;
    pre = q.size();
    if (clr) begin
      q.delete();
      m_ovf  = 1'b0;
      m_csum = '0;
    end else begin
      if (iv && pre == DEPTH) m_ovf = 1'b1;
      if (ordy && pre > 0) begin
        exp = q.pop_front();
        check("pop_data", 32'(bus.out_data), 32'(exp));
        m_csum = m_csum + exp[DATA_W-1:0];
      end
      if (iv && pre < DEPTH) q.push_back({st, rc});
    end
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(q.size()));
    check("fill_state", 32'(fill_state), 32'(model_fill()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    if (q.size() > 0) check("head_data", 32'(bus.out_data), 32'(q[0]));
`ifdef RC_FIFO_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(m_csum));
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // {iv, st, rc, ordy, clr, e_cnt, e_fill, e_ovf}
    vecs[0]  = '{1'b1, 2'b01, 4'hA, 1'b0, 1'b0, 1, 2'b01, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 0, 2'b00, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 4'h1, 1'b0, 1'b0, 1, 2'b01, 1'b0};
    vecs[3]  = '{1'b1, 2'b10, 4'h2, 1'b0, 1'b0, 2, 2'b01, 1'b0};
    vecs[4]  = '{1'b1, 2'b10, 4'h3, 1'b0, 1'b0, 3, 2'b01, 1'b0};
    vecs[5]  = '{1'b1, 2'b10, 4'h4, 1'b0, 1'b0, 4, 2'b10, 1'b0};
    vecs[6]  = '{1'b1, 2'b11, 4'h5, 1'b0, 1'b0, 4, 2'b10, 1'b1};
    vecs[7]  = '{1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 3, 2'b01, 1'b1};
    vecs[8]  = '{1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 2, 2'b01, 1'b1};
    vecs[9]  = '{1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 1, 2'b01, 1'b1};
    vecs[10] = '{1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 0, 2'b00, 1'b1};
    vecs[11] = '{1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 0, 2'b00, 1'b1};
    vecs[12] = '{1'b0, 2'b00, 4'h0, 1'b0, 1'b1, 0, 2'b00, 1'b0};

    m_ovf  = 1'b0;
    m_csum = '0;
    reset  = 1'b0;
    clear  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.state_in  = '0;
    bus.rc_in     = '0;
    bus.out_ready = 1'b0;

    // Reset held for two cycles; outputs must already be at reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_fill", 32'(fill_state), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Basic flow, fill, overflow and in-order drain from the table.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].iv, vecs[i].st, vecs[i].rc, vecs[i].ordy, vecs[i].clr);
      check("vec_count", 32'(count), 32'(vecs[i].e_cnt));
      check("vec_fill", 32'(fill_state), 32'(vecs[i].e_fill));
      check("vec_overflow", 32'(overflow), 32'(vecs[i].e_ovf));
      if (i == 0) check("vec_first_data", 32'(bus.out_data), 32'h1A);
    end

    // Streaming across pointer wrap: one entry preloaded, then 10 push+pop cycles.
    step(1'b1, 2'b00, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'b01, 4'(i), 1'b1, 1'b0);
      check("stream_count", 32'(count), 32'd1);
    end
    step(1'b0, 2'b00, 4'h0, 1'b1, 1'b0);
    check("stream_drained", 32'(count), 32'd0);

    // Clear priority over simultaneous push, pop and overflow.
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, 4'(i + 6), 1'b0, 1'b0);
    step(1'b1, 2'b11, 4'hE, 1'b0, 1'b0);
    check("pre_clear_ovf", 32'(overflow), 32'd1);
    step(1'b1, 2'b11, 4'hD, 1'b1, 1'b1);
    check("clear_count", 32'(count), 32'd0);
    check("clear_fill", 32'(fill_state), 32'd0);
    check("clear_ovf", 32'(overflow), 32'd0);
    check("clear_out_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset between edges with three entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 4'(i + 3), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("areset_count", 32'(count), 32'd0);
    check("areset_out_valid", 32'(bus.out_valid), 32'd0);
    check("areset_in_ready", 32'(bus.in_ready), 32'd1);
    check("areset_fill", 32'(fill_state), 32'd0);
    q.delete();
    m_ovf  = 1'b0;
    m_csum = '0;
    @(negedge clk);
    reset = 1'b1;
    idle();
    step(1'b1, 2'b01, 4'h7, 1'b0, 1'b0);
    step(1'b0, 2'b00, 4'h0, 1'b1, 1'b0);

`ifdef RC_FIFO_CHECKSUM_EN
    // Checksum: 9 + 8 + 3 = 20 -> 4'h4, then cleared.
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
    step(1'b1, 2'b00, 4'h9, 1'b0, 1'b0);
    step(1'b1, 2'b00, 4'h8, 1'b0, 1'b0);
    step(1'b1, 2'b00, 4'h3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 4'h0, 1'b1, 1'b0);
    check("csum_value", 32'(checksum), 32'h4);
    step(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
    check("csum_clear", 32'(checksum), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
